// File: rtl/cache_replacement_unit_if.sv
// cache_replacement_unit_if: victim lookup and policy update bus of the replacement unit.
// Ports (master = cache control side, slave = replacement unit):
//   req_valid/req_set/req_valid_bits          lookup request
//   victim_valid/victim_way/victim_way_bin    registered victim response
//   upd_valid/upd_set/upd_way/upd_demote      policy state update (touch or demote)
interface cache_replacement_unit_if #(
   parameter int N_WAYS     = 4,
   parameter int LINE_OFF_W = 4
);
   localparam int NWAY_W = $clog2(N_WAYS);
   logic                  req_valid;
   logic [LINE_OFF_W-1:0] req_set;
   logic [N_WAYS-1:0]     req_valid_bits;
   logic                  victim_valid;
   logic [N_WAYS-1:0]     victim_way;
   logic [NWAY_W-1:0]     victim_way_bin;
   logic                  upd_valid;
   logic [LINE_OFF_W-1:0] upd_set;
   logic [N_WAYS-1:0]     upd_way;
   logic                  upd_demote;
   modport master (
      output req_valid, req_set, req_valid_bits, upd_valid, upd_set, upd_way, upd_demote,
      input  victim_valid, victim_way, victim_way_bin
   );
   modport slave (
      input  req_valid, req_set, req_valid_bits, upd_valid, upd_set, upd_way, upd_demote,
      output victim_valid, victim_way, victim_way_bin
   );
endinterface

// File: rtl/cache_replacement_unit.sv
// cache_replacement_unit: per-set replacement policy state (LRU / PLRU_mru / PLRU_tree / RANDOM)
// with invalid-first victim selection and an init sweep after reset or flush.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   flush  one-cycle pulse, restarts the init sweep when idle
//   ready  1 when idle; lookups and updates only accepted then
//   err    sticky flag, an accepted update had a non-one-hot way
//   bus    lookup/victim and update signals (slave side)
module cache_replacement_unit #(
   parameter int N_WAYS     = 4,
   parameter int LINE_OFF_W = 4,
   parameter int REP_POLICY = 0,
   parameter int NWAY_W     = $clog2(N_WAYS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   output logic                     ready,
   output logic                     err,
   cache_replacement_unit_if.slave  bus
);
   localparam int N_SETS = 2 ** LINE_OFF_W;
   // Wide enough for LRU ranks, which is the largest of the policy encodings
   localparam int ST_W = N_WAYS * NWAY_W;
   typedef enum logic {INIT, IDLE} state_t;
   state_t                state_q, state_d;
   logic [LINE_OFF_W-1:0] cnt_q, cnt_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  err_q, err_d;
   logic                  vv_q, vv_d;
   logic [N_WAYS-1:0]     vway_q, vway_d;
   logic [NWAY_W-1:0]     vbin_q, vbin_d;
   logic [ST_W-1:0]       st_mem [N_SETS];
   logic                  wr_en;
   logic [LINE_OFF_W-1:0] wr_set;
   logic [ST_W-1:0]       wr_data;
   logic                  acc_req, acc_upd, upd_oh, any_inv;
   logic [NWAY_W-1:0]     upd_bin, inv_bin, vic_bin;

   function automatic logic [ST_W-1:0] pol_init();
      logic [ST_W-1:0] s;
      s = '0;
      if (REP_POLICY == 0)
         for (int i = 0; i < N_WAYS; i++) s[i*NWAY_W +: NWAY_W] = NWAY_W'(i);
      return s;
   endfunction

   function automatic logic [NWAY_W-1:0] pol_victim(input logic [ST_W-1:0] s,
                                                    input logic [NWAY_W-1:0] rnd);
      logic [NWAY_W-1:0] v;
      logic [N_WAYS-1:0] t;
      logic [NWAY_W:0]   n;
      v = '0;
      t = s[N_WAYS-1:0];
      n = {{NWAY_W{1'b0}}, 1'b1};
      if (REP_POLICY == 0) begin
         for (int i = N_WAYS - 1; i >= 0; i--) if (s[i*NWAY_W +: NWAY_W] == '0) v = NWAY_W'(i);
      end else if (REP_POLICY == 1) begin
         for (int i = N_WAYS - 1; i >= 0; i--) if (!t[i]) v = NWAY_W'(i);
      end else if (REP_POLICY == 2) begin
         // Walk root to leaf; internal nodes are < N_WAYS so the low bits index them
         for (int k = 0; k < NWAY_W; k++) n = {n[NWAY_W-1:0], t[n[NWAY_W-1:0]]};
         v = n[NWAY_W-1:0];
      end else begin
         v = rnd;
      end
      return v;
   endfunction

   function automatic logic [ST_W-1:0] pol_update(input logic [ST_W-1:0] s,
                                                  input logic [NWAY_W-1:0] w,
                                                  input logic dem);
      logic [ST_W-1:0]   o;
      logic [NWAY_W-1:0] r, ri;
      logic [N_WAYS-1:0] b, oh;
      logic [NWAY_W:0]   n;
      o  = s;
      r  = '0;
      b  = s[N_WAYS-1:0];
      oh = N_WAYS'(1) << w;
      n  = {1'b1, w};
      if (REP_POLICY == 0) begin
         for (int i = 0; i < N_WAYS; i++) if (w == NWAY_W'(i)) r = s[i*NWAY_W +: NWAY_W];
         for (int i = 0; i < N_WAYS; i++) begin
            ri = s[i*NWAY_W +: NWAY_W];
            o[i*NWAY_W +: NWAY_W] = (w == NWAY_W'(i)) ? (dem ? '0 : NWAY_W'(N_WAYS - 1)) :
                                    (!dem && ri > r) ? ri - 1'b1 :
                                    (dem && ri < r)  ? ri + 1'b1 : ri;
         end
      end else if (REP_POLICY == 1) begin
         b = dem ? (b & ~oh) : (b | oh);
         // Saturated MRU bits would leave no victim, so restart from the touched way
         if (&b) b = oh;
         o[N_WAYS-1:0] = b;
      end else if (REP_POLICY == 2) begin
         // Leaf to root: a node points away from w on touch, toward w on demote
         for (int k = 0; k < NWAY_W; k++) begin
            b[n[NWAY_W:1]] = dem ? n[0] : ~n[0];
            n = n >> 1;
         end
         o[N_WAYS-1:0] = b;
      end
      return o;
   endfunction

   always_comb begin
      acc_req = ready && bus.req_valid;
      acc_upd = ready && bus.upd_valid;
      upd_oh  = (bus.upd_way != '0) && ((bus.upd_way & (bus.upd_way - 1'b1)) == '0);
      upd_bin = '0;
      for (int i = 0; i < N_WAYS; i++) if (bus.upd_way[i]) upd_bin = NWAY_W'(i);
      inv_bin = '0;
      for (int i = N_WAYS - 1; i >= 0; i--) if (!bus.req_valid_bits[i]) inv_bin = NWAY_W'(i);
      any_inv = ~&bus.req_valid_bits;
      vic_bin = any_inv ? inv_bin : pol_victim(st_mem[bus.req_set], lfsr_q[NWAY_W-1:0]);
      state_d = (state_q == INIT) ? ((cnt_q == '1) ? IDLE : INIT) : (flush ? INIT : IDLE);
      cnt_d   = (state_q == INIT) ? cnt_q + 1'b1 : '0;
      lfsr_d  = ready ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
      err_d   = err_q | (acc_upd && !upd_oh);
      vv_d    = acc_req;
      vbin_d  = acc_req ? vic_bin : vbin_q;
      vway_d  = acc_req ? N_WAYS'(1) << vic_bin : vway_q;
      wr_en   = (state_q == INIT) || (acc_upd && upd_oh && REP_POLICY != 3);
      wr_set  = (state_q == INIT) ? cnt_q : bus.upd_set;
      wr_data = (state_q == INIT) ? pol_init() : pol_update(st_mem[bus.upd_set], upd_bin, bus.upd_demote);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         lfsr_q  <= 16'hACE1;
         err_q   <= 1'b0;
         vv_q    <= 1'b0;
         vway_q  <= '0;
         vbin_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         err_q   <= err_d;
         vv_q    <= vv_d;
         vway_q  <= vway_d;
         vbin_q  <= vbin_d;
      end
   end

   // Policy state needs no reset: the init sweep writes every set before ready rises
   always_ff @(posedge clk) begin
      if (wr_en) st_mem[wr_set] <= wr_data;
   end

   assign ready              = (state_q == IDLE);
   assign err                = err_q;
   assign bus.victim_valid   = vv_q;
   assign bus.victim_way     = vway_q;
   assign bus.victim_way_bin = vbin_q;
endmodule

// File: tb/tb_cache_replacement_unit.sv
// tb_cache_replacement_unit: directed checks of all four policies side by side on shared stimulus.
module tb_cache_replacement_unit;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_set = '0;
   logic [3:0] req_bits = '0;
   logic       upd_valid = 1'b0;
   logic [3:0] upd_set = '0;
   logic [3:0] upd_way = '0;
   logic       upd_demote = 1'b0;
   logic       rdy [4];
   logic       errs [4];
   logic       vv [4];
   logic [3:0] vway [4];
   logic [1:0] vbin [4];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   // g = REP_POLICY: 0 LRU, 1 PLRU_mru, 2 PLRU_tree, 3 RANDOM
   for (genvar g = 0; g < 4; g++) begin : g_dut
      cache_replacement_unit_if #(.N_WAYS(4), .LINE_OFF_W(4)) bus ();
      assign bus.req_valid      = req_valid;
      assign bus.req_set        = req_set;
      assign bus.req_valid_bits = req_bits;
      assign bus.upd_valid      = upd_valid;
      assign bus.upd_set        = upd_set;
      assign bus.upd_way        = upd_way;
      assign bus.upd_demote     = upd_demote;
      assign vv[g]              = bus.victim_valid;
      assign vway[g]            = bus.victim_way;
      assign vbin[g]            = bus.victim_way_bin;
      cache_replacement_unit #(.N_WAYS(4), .LINE_OFF_W(4), .REP_POLICY(g)) dut (
         .clk(clk), .reset(reset), .flush(flush), .ready(rdy[g]), .err(errs[g]), .bus(bus.slave)
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lookup(input logic [3:0] s, input logic [3:0] bits);
      req_valid = 1'b1;
      req_set   = s;
      req_bits  = bits;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic upd(input logic [3:0] s, input logic [3:0] w, input logic d);
      upd_valid  = 1'b1;
      upd_set    = s;
      upd_way    = w;
      upd_demote = d;
      tick();
      upd_valid  = 1'b0;
      upd_demote = 1'b0;
   endtask

   // Count cycles until ready while requesting and pulsing flush mid-sweep; both must be ignored
   task automatic wait_ready(input string tag);
      int  n = 0;
      logic seen = 1'b0;
      req_valid = 1'b1;
      req_set   = 4'd0;
      req_bits  = 4'hF;
      while (!rdy[0] && n < 40) begin
         flush = (n == 3);
         tick();
         seen |= vv[0];
         n++;
      end
      flush     = 1'b0;
      req_valid = 1'b0;
      chk({tag, "_len"}, n, 16);
      chk({tag, "_no_victim"}, seen, 0);
      for (int g = 0; g < 4; g++) chk({tag, "_ready"}, rdy[g], 1);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_ready", rdy[0], 0);
      chk("rst_vv", vv[0], 0);
      chk("rst_way", vway[0], 0);
      chk("rst_bin", vbin[0], 0);
      chk("rst_err", errs[0], 0);
      reset     = 1'b1;
      upd_valid = 1'b1;
      upd_way   = 4'b0110;
      wait_ready("init");
      upd_valid = 1'b0;
      upd_way   = '0;
      chk("init_upd_ignored_err", errs[0], 0);

      lookup(4'd3, 4'hF);
      chk("lru_init_vv", vv[0], 1);
      chk("lru_init_way", vway[0], 4'b0001);
      chk("lru_init_bin", vbin[0], 0);
      tick();
      chk("vv_pulse", vv[0], 0);
      chk("way_hold", vway[0], 4'b0001);

      upd(4'd3, 4'b0001, 1'b0);
      upd(4'd3, 4'b0010, 1'b0);
      upd(4'd3, 4'b0100, 1'b0);
      lookup(4'd3, 4'hF);
      chk("lru_touch_way", vway[0], 4'b1000);
      chk("lru_touch_bin", vbin[0], 3);
      upd(4'd3, 4'b0010, 1'b1);
      lookup(4'd3, 4'hF);
      chk("lru_demote_way", vway[0], 4'b0010);
      chk("lru_demote_bin", vbin[0], 1);

      lookup(4'd5, 4'b1011);
      for (int g = 0; g < 4; g++) begin
         chk("inv_first_way", vway[g], 4'b0100);
         chk("inv_first_bin", vbin[g], 2);
      end

      upd_valid = 1'b1;
      upd_set   = 4'd6;
      upd_way   = 4'b0001;
      lookup(4'd6, 4'hF);
      upd_valid = 1'b0;
      for (int g = 0; g < 3; g++) chk("same_cycle_old_state", vway[g], 4'b0001);
      lookup(4'd6, 4'hF);
      chk("lru_after_touch0", vway[0], 4'b0010);
      chk("mru_after_touch0", vway[1], 4'b0010);
      chk("tree_after_touch0", vbin[2], 2);

      upd(4'd7, 4'b0001, 1'b0);
      upd(4'd7, 4'b0010, 1'b0);
      upd(4'd7, 4'b0100, 1'b0);
      upd(4'd7, 4'b1000, 1'b0);
      lookup(4'd7, 4'hF);
      for (int g = 0; g < 3; g++) chk("touch_all_way", vway[g], 4'b0001);
      upd(4'd7, 4'b1000, 1'b1);
      lookup(4'd7, 4'hF);
      chk("lru_demote3", vway[0], 4'b1000);
      chk("mru_demote3", vway[1], 4'b0001);
      chk("tree_demote3", vway[2], 4'b1000);

      chk("err_clean", errs[0], 0);
      upd(4'd3, 4'b0110, 1'b0);
      for (int g = 0; g < 4; g++) chk("err_set", errs[g], 1);
      repeat (3) tick();
      chk("err_sticky", errs[0], 1);

      flush = 1'b1;
      lookup(4'd3, 4'hF);
      flush = 1'b0;
      chk("flush_req_vv", vv[0], 1);
      chk("bad_upd_dropped", vway[0], 4'b0010);
      chk("flush_ready_low", rdy[0], 0);
      wait_ready("flush");
      chk("err_survives_flush", errs[0], 1);
      lookup(4'd3, 4'hF);
      chk("lru_after_flush", vway[0], 4'b0001);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("midrst_ready", rdy[0], 0);
      chk("midrst_vv", vv[0], 0);
      chk("midrst_way", vway[0], 0);
      chk("midrst_bin", vbin[0], 0);
      chk("midrst_err", errs[0], 0);
      tick();
      tick();
      reset = 1'b1;
      wait_ready("rst_sweep");
      lookup(4'd3, 4'hF);
      chk("lru_after_rst", vway[0], 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
